// File: rtl/alu_sequencer.sv
// Sequencer that owns the shared 32-bit combinational ALU: single-pass ops take one ALU
// pass, MULTU runs a shift-add loop through the ALU's ADD path to build a 64-bit product.
module alu_sequencer #(
    parameter int WIDTH    = 32,
    parameter int MUL_ITER = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       req_funct,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_lo,
    output logic [WIDTH-1:0] resp_hi,
    output logic             resp_err,
    output logic             busy,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [5:0]       alu_signal,
    input  logic [WIDTH-1:0] alu_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MULTU = 6'b011001;

    localparam logic [4:0] LAST_ITER = 5'(MUL_ITER - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [5:0]       r_funct;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [4:0]       r_cnt;
    logic             r_err;

    logic             w_single;
    logic [WIDTH-1:0] w_alu_a;
    logic [WIDTH-1:0] w_alu_b;
    logic [5:0]       w_alu_signal;
    logic             w_carry;

    always_comb begin
        w_single = 1'b0;
        case (req_funct)
            F_AND, F_OR, F_ADD, F_SUB, F_SLT: w_single = 1'b1;
            default:                          w_single = 1'b0;
        endcase
    end

    always_comb begin
        w_alu_a      = '0;
        w_alu_b      = '0;
        w_alu_signal = '0;
        case (r_state)
            S_EXEC: begin
                w_alu_a      = r_a;
                w_alu_b      = r_b;
                w_alu_signal = r_funct;
            end
            S_MUL: begin
                w_alu_a      = r_hi;
                w_alu_b      = r_lo[0] ? r_a : '0;
                w_alu_signal = F_ADD;
            end
            default: ;
        endcase
    end

    // Carry-out of the ALU addition recovered from the operand and sum MSBs.
    assign w_carry = (r_hi[WIDTH-1] & w_alu_b[WIDTH-1])
                   | ((r_hi[WIDTH-1] | w_alu_b[WIDTH-1]) & ~alu_out[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_funct <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_a     <= req_a;
                        r_b     <= req_b;
                        r_funct <= req_funct;
                        if (w_single) begin
                            r_state <= S_EXEC;
                        end else if (req_funct == F_MULTU) begin
                            r_hi    <= '0;
                            r_lo    <= req_b;
                            r_cnt   <= '0;
                            r_state <= S_MUL;
                        end else begin
                            r_hi    <= '0;
                            r_lo    <= '0;
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_EXEC: begin
                    r_lo    <= alu_out;
                    r_hi    <= '0;
                    r_err   <= 1'b0;
                    r_state <= S_DONE;
                end
                S_MUL: begin
                    // 65-bit {carry, sum, lo} shifted right by one, low 64 bits kept.
                    {r_hi, r_lo} <= {w_carry, alu_out, r_lo[WIDTH-1:1]};
                    r_cnt        <= r_cnt + 5'd1;
                    if (r_cnt == LAST_ITER) begin
                        r_err   <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    if (resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign resp_valid = (r_state == S_DONE);
    assign resp_lo    = resp_valid ? r_lo : '0;
    assign resp_hi    = resp_valid ? r_hi : '0;
    assign resp_err   = resp_valid & r_err;
    assign alu_a      = w_alu_a;
    assign alu_b      = w_alu_b;
    assign alu_signal = w_alu_signal;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: models the external ALU and checks responses
// against a scoreboard of expected results queued at request time.
module tb_alu_sequencer;

    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MULTU = 6'b011001;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_funct;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_lo;
    logic [31:0] resp_hi;
    logic        resp_err;
    logic        busy;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [5:0]  alu_signal;
    logic [31:0] alu_out;

    typedef struct {
        string       tag;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_sequencer #(.WIDTH(32), .MUL_ITER(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct  (req_funct),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_lo    (resp_lo),
        .resp_hi    (resp_hi),
        .resp_err   (resp_err),
        .busy       (busy),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_signal (alu_signal),
        .alu_out    (alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference combinational ALU sitting outside the sequencer.
    always_comb begin
        alu_out = 32'h0;
        case (alu_signal)
            F_AND:   alu_out = alu_a & alu_b;
            F_OR:    alu_out = alu_a | alu_b;
            F_ADD:   alu_out = alu_a + alu_b;
            F_SUB:   alu_out = alu_a - alu_b;
            F_SLT:   alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_out = 32'h0;
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_resp_lohi"}, {resp_hi, resp_lo}, 64'd0);
        check({tag, "_resp_err"}, 64'(resp_err), 64'd0);
        check({tag, "_alu"}, {alu_a, alu_b}, 64'd0);
        check({tag, "_alu_sig"}, 64'(alu_signal), 64'd0);
    endtask

    // Drives one request for one cycle; returns in the first cycle after accept.
    task automatic issue(input string tag, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input bit push, input logic [31:0] lo,
                         input logic [31:0] hi, input logic err, input int lat);
        exp_t e;
        check({tag, "_accept_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_funct = f;
        req_a     = a;
        req_b     = b;
        if (push) begin
            e.tag = tag; e.lo = lo; e.hi = hi; e.err = err; e.lat = lat;
            sb.push_back(e);
        end
        tick();
        req_valid = 1'b0;
        req_funct = 6'h3f;
        req_a     = 32'hDEAD_BEEF;
        req_b     = 32'hCAFE_F00D;
    endtask

    // Waits for resp_valid, then compares against the oldest scoreboard entry.
    task automatic await_resp(input string tag);
        exp_t e;
        int   k = 1;
        int   nbusy = 0;
        while (!resp_valid && k < 200) begin
            if (busy) nbusy++;
            tick();
            k++;
        end
        if (busy) nbusy++;
        check({tag, "_resp_seen"}, 64'(resp_valid), 64'd1);
        check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_latency"}, 64'(k), 64'(e.lat));
            check({tag, "_busy_cycles"}, 64'(nbusy), 64'(e.lat));
            check({tag, "_lo"}, 64'(resp_lo), 64'(e.lo));
            check({tag, "_hi"}, 64'(resp_hi), 64'(e.hi));
            check({tag, "_err"}, 64'(resp_err), 64'(e.err));
            check({tag, "_done_alu_sig"}, 64'(alu_signal), 64'd0);
            $display("txn %s: lo=%h hi=%h err=%0d latency=%0d", tag, resp_lo, resp_hi,
                     resp_err, k);
        end
    endtask

    task automatic complete(input string tag);
        resp_ready = 1'b1;
        tick();
        check({tag, "_back_idle_ready"}, 64'(req_ready), 64'd1);
        check({tag, "_back_idle_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] lo, input logic [31:0] hi,
                          input logic err, input int lat);
        issue(tag, f, a, b, 1'b1, lo, hi, err, lat);
        await_resp(tag);
        complete(tag);
    endtask

    initial begin
        logic [63:0] prod;
        logic [31:0] ma;
        logic [31:0] mb;
        int          stray;

        reset      = 1'b0;
        req_valid  = 1'b0;
        req_funct  = 6'h0;
        req_a      = 32'h0;
        req_b      = 32'h0;
        resp_ready = 1'b1;
        repeat (3) tick();
        check_idle("reset");
        reset = 1'b1;
        tick();

        run_op("add_5_7", F_ADD, 32'd5, 32'd7, 32'd12, 32'd0, 1'b0, 2);
        run_op("sub_3_5", F_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 32'd0, 1'b0, 2);
        run_op("slt_m1_1", F_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 1'b0, 2);
        run_op("slt_1_m1", F_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 2);
        run_op("or_a5_5a", F_OR, 32'hA5A5_0000, 32'h005A_5A5A, 32'hA5FF_5A5A, 32'd0, 1'b0, 2);

        run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001,
               32'hFFFF_FFFE, 1'b0, 33);
        run_op("multu_6_7", F_MULTU, 32'd6, 32'd7, 32'd42, 32'd0, 1'b0, 33);
        for (int i = 0; i < 2; i++) begin
            ma   = $urandom;
            mb   = $urandom;
            prod = 64'(ma) * 64'(mb);
            run_op($sformatf("multu_rand%0d", i), F_MULTU, ma, mb, prod[31:0], prod[63:32],
                   1'b0, 33);
        end

        // Backpressure: response held for four cycles with resp_ready low.
        resp_ready = 1'b0;
        issue("add_bp", F_ADD, 32'd1, 32'd1, 1'b1, 32'd2, 32'd0, 1'b0, 2);
        await_resp("add_bp");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp%0d_valid", i), 64'(resp_valid), 64'd1);
            check($sformatf("bp%0d_lo", i), 64'(resp_lo), 64'd2);
            check($sformatf("bp%0d_req_ready", i), 64'(req_ready), 64'd0);
            tick();
        end
        complete("add_bp");

        issue("illegal", 6'b111111, 32'h1234, 32'h1234, 1'b1, 32'd0, 32'd0, 1'b1, 1);
        check("illegal_alu_sig", 64'(alu_signal), 64'd0);
        await_resp("illegal");
        complete("illegal");

        // Reset pulse during the 10th MUL cycle aborts with no response.
        issue("multu_abort", F_MULTU, 32'd123, 32'd456, 1'b0, 32'd0, 32'd0, 1'b0, 0);
        repeat (9) tick();
        check("abort_busy_mid_mul", 64'(busy), 64'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_idle("abort");
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            if (resp_valid) stray++;
            tick();
        end
        check("abort_no_response", 64'(stray), 64'd0);
        $display("txn multu_abort: aborted by reset, stray responses=%0d", stray);

        run_op("and_after_reset", F_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000,
               32'd0, 1'b0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle sequencer that owns the shared 32-bit ALU and runs operations on it through a valid/ready request/response handshake.

- Single-pass funct codes (AND, OR, ADD, SUB, SLT) make one ALU pass.
- MULTU (6'b011001) runs a 32-iteration shift-add loop that uses the ALU's ADD path, producing a 64-bit HI/LO product.
- The block sits between the decode/control stage and the external combinational ALU, driving its dataA/dataB/Signal inputs.

## Interface
Parameters:
- WIDTH, 32, datapath width; the ALU is 32-bit, so only 32 is supported.
- MUL_ITER, 32, number of shift-add iterations for MULTU; equals WIDTH.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset: sampled on the clk rising edge, and reset asserted = 0.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request; high only in IDLE.
- req_funct  in  6  operation: AND 6'b100100, OR 6'b100101, ADD 6'b100000, SUB 6'b100010, SLT 6'b101010, MULTU 6'b011001.
- req_a  in  32  operand A (multiplicand for MULTU).
- req_b  in  32  operand B (multiplier for MULTU).
- resp_valid  out  1  result available; held until accepted.
- resp_ready  in  1  consumer accepts the result.
- resp_lo  out  32  result (LO word for MULTU).
- resp_hi  out  32  HI word for MULTU; 0 for every other op.
- resp_err  out  1  request had an unsupported funct.
- busy  out  1  state != IDLE.
- alu_a  out  32  to ALU dataA.
- alu_b  out  32  to ALU dataB.
- alu_signal  out  6  to ALU Signal.
- alu_out  in  32  from ALU dataOut (combinational); the ALU's own reset input is tied inactive.

## Operation
States are IDLE, EXEC, MUL and DONE. Registers: a_reg, b_reg, funct_reg, hi_reg, lo_reg, cnt (5 bits), err_reg.

**IDLE**
- req_ready=1; alu_a=alu_b=0; alu_signal=0.
- On req_valid: capture req_a, req_b, req_funct.
- AND/OR/ADD/SUB/SLT -> EXEC.
- MULTU -> MUL with hi_reg=0, lo_reg=req_b, cnt=0.
- Any other funct -> DONE with lo=hi=0, err=1.

**EXEC**
- Drive alu_a=a_reg, alu_b=b_reg, alu_signal=funct_reg.
- Capture lo_reg=alu_out, hi_reg=0, err=0, then go to DONE.
- SLT semantics (signed, 1/0) come from the ALU unchanged.

**MUL** (one iteration per cycle)
- Drive alu_signal=ADD, alu_a=hi_reg, alu_b = lo_reg[0] ? a_reg : 0.
- Form sum=alu_out and carry = (hi_reg[31]&alu_b[31]) | ((hi_reg[31]|alu_b[31]) & ~sum[31]).
- Update {hi_reg,lo_reg} <= {carry, sum, lo_reg[31:1]} (a 65-bit value shifted right by 1, keeping 64).
- Increment cnt; after the iteration where cnt==MUL_ITER-1, go to DONE with err=0.
- The block never uses the '+' operator on the data path; all additions go through the ALU.

**DONE**
- resp_valid=1; resp_lo/resp_hi/resp_err drive the registered values; alu outputs are 0.
- On resp_valid&&resp_ready -> IDLE.
- No request is accepted in the same cycle as the response handshake, because req_ready is low in DONE.

General rules:
- resp_* are stable while resp_valid=1 and resp_ready=0.
- Request fields are don't-care when req_ready=0.
- Reset (reset=0 at any edge, in any state, including mid-MUL):
  - Return to IDLE and abort the operation with no response.
  - resp_valid=0, resp_lo=resp_hi=0, resp_err=0, busy=0, req_ready=1 after the edge.
  - alu_*=0, cnt=0.
- Multiplication is unsigned, and the 64-bit product is exact for all operand values.

## Timing
- Request is accepted at edge N (req_valid&&req_ready).
- Single-pass op:
  - EXEC occupies cycle N..N+1.
  - resp_valid rises after edge N+2, so latency is 2 cycles.
  - Minimum period between accepts is 3 cycles with resp_ready held high.
- MULTU:
  - MUL occupies 32 cycles.
  - resp_valid rises after edge N+33.
  - Minimum period is 34 cycles.
- Illegal funct: resp_valid rises after edge N+1.
- Backpressure adds one cycle per cycle that resp_ready stays low while in DONE.
- alu_out is sampled at the end of the same cycle in which alu_a/alu_b/alu_signal are driven; the ALU path must meet a single cycle.

## Test plan
- ADD, req_a=5, req_b=7, resp_ready=1 -> resp_valid 2 cycles after accept; resp_lo=12, resp_hi=0, resp_err=0; busy high for 2 cycles.
- SUB 3-5, then SLT with a=0xFFFFFFFF (-1), b=1 -> resp_lo=0xFFFFFFFE, then resp_lo=1.
- MULTU 0xFFFFFFFF×0xFFFFFFFF -> resp_valid 33 cycles after accept; resp_hi=0xFFFFFFFE, resp_lo=0x00000001. Also check MULTU 6×7 -> hi=0, lo=42.
- Backpressure: ADD 1+1 with resp_ready=0 for 4 cycles -> resp_valid and resp_lo=2 held stable, req_ready=0 throughout; one cycle after resp_ready=1, req_ready=1.
- Illegal funct 6'b111111 with a=b=0x1234 -> resp_valid 1 cycle after accept; resp_err=1, resp_lo=resp_hi=0; the ALU is never driven (alu_signal stays 0).
- Drive reset=0 for one edge during the 10th MUL cycle -> next cycle state=IDLE, busy=0, req_ready=1, resp_valid=0; no response is produced. A following AND 0xF0F0&0xFF00 -> 0xF000.
